// File: rtl/uut_run_harness_pkg.sv
// Shared types and constants for the UUT run harness.
package uut_run_harness_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE,
    TOUT
  } state_t;

  localparam int unsigned MAX_RESULT_W = 1024;

  // Result pattern reported when the core times out: all ones in the low 'width' bits.
  function automatic logic [MAX_RESULT_W-1:0] tout_pattern(input int unsigned width);
    logic [MAX_RESULT_W-1:0] p;
    p = '0;
    for (int unsigned i = 0; i < MAX_RESULT_W; i++) begin
      if (i < width) p[i] = 1'b1;
    end
    return p;
  endfunction

endpackage

// File: rtl/uut_run_harness_counter.sv
// run_cycle_counter: clearable, saturating run-latency counter with a terminal-count flag.
module run_cycle_counter #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned TERMINAL = 1048576
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             terminal
);

  // clear together with enable loads 1 so the first counted cycle reads as 1
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= enable ? CNT_W'(1) : '0;
    end else if (enable && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign terminal = (count == CNT_W'(TERMINAL));

endmodule

// File: rtl/uut_run_harness.sv
// Run harness between the autotest controller and the core under test: run window,
// latency measurement, result capture. Timeout path enabled by `define UUT_RUN_TIMEOUT_EN.
module uut_run_harness
  import uut_run_harness_pkg::*;
#(
  parameter int unsigned OUTPUT_SIZE_1  = 32,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rst_uut,
  output logic                     end_uut,
  output logic [OUTPUT_SIZE_1-1:0] result_out,
  output logic                     uut_rst,
  input  logic                     uut_end,
  input  logic [OUTPUT_SIZE_1-1:0] uut_result,
  output logic [CNT_W-1:0]         cycle_count,
  output logic                     timeout
);

  state_t           state, state_next;
  logic             cnt_clear, cnt_en;
  logic             start_run, capture_done;
  logic [CNT_W-1:0] count;
  logic             terminal;

`ifdef UUT_RUN_TIMEOUT_EN
  localparam logic [OUTPUT_SIZE_1-1:0] TOUT_RESULT =
    OUTPUT_SIZE_1'(tout_pattern(OUTPUT_SIZE_1));
  logic capture_tout;
`else
  logic unused_terminal;
  assign unused_terminal = terminal;
`endif

  run_cycle_counter #(
    .CNT_W    (CNT_W),
    .TERMINAL (TIMEOUT_CYCLES)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clear),
    .enable   (cnt_en),
    .count    (count),
    .terminal (terminal)
  );

  always_comb begin
    state_next   = state;
    cnt_clear    = 1'b0;
    cnt_en       = 1'b0;
    start_run    = 1'b0;
    capture_done = 1'b0;
`ifdef UUT_RUN_TIMEOUT_EN
    capture_tout = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rst_uut) begin
          state_next = RUN;
          start_run  = 1'b1;
          cnt_clear  = 1'b1;
          cnt_en     = 1'b1;
        end
      end
      RUN: begin
        // abort beats completion, completion beats timeout
        if (rst_uut) begin
          state_next = IDLE;
        end else if (uut_end) begin
          state_next   = DONE;
          capture_done = 1'b1;
        end
`ifdef UUT_RUN_TIMEOUT_EN
        else if (terminal) begin
          state_next   = TOUT;
          capture_tout = 1'b1;
        end
`endif
        else begin
          cnt_en = 1'b1;
        end
      end
      DONE, TOUT: begin
        if (rst_uut) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      end_uut     <= 1'b0;
      timeout     <= 1'b0;
      uut_rst     <= 1'b1;
      result_out  <= '0;
      cycle_count <= '0;
    end else begin
      state   <= state_next;
      uut_rst <= (state_next != RUN);
      end_uut <= (state_next == DONE) || (state_next == TOUT);
`ifdef UUT_RUN_TIMEOUT_EN
      timeout <= (state_next == TOUT);
`else
      timeout <= 1'b0;
`endif
      if (start_run) begin
        result_out  <= '0;
        cycle_count <= '0;
      end
      if (capture_done) begin
        result_out  <= uut_result;
        cycle_count <= count;
      end
`ifdef UUT_RUN_TIMEOUT_EN
      if (capture_tout) begin
        result_out  <= TOUT_RESULT;
        cycle_count <= CNT_W'(TIMEOUT_CYCLES);
      end
`endif
    end
  end

endmodule

// File: tb/tb_uut_run_harness.sv
// Scoreboard bench for uut_run_harness; expectations come from a run-outcome model.
module tb_uut_run_harness;

  localparam int unsigned OW  = 32;
  localparam int unsigned CW  = 32;
  localparam int unsigned TO  = 16;
  localparam int unsigned INF = 32'hFFFF_FFFF;
`ifdef UUT_RUN_TIMEOUT_EN
  localparam bit TOUT_EN = 1'b1;
`else
  localparam bit TOUT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, rst_uut, uut_end;
  logic [OW-1:0] uut_result;
  logic          end_uut, uut_rst, timeout;
  logic [OW-1:0] result_out;
  logic [CW-1:0] cycle_count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  typedef struct {
    logic [OW-1:0] result;
    logic [CW-1:0] cycles;
    logic          tout;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic end_prev = 1'b0;

  always #5 clk = ~clk;

  uut_run_harness #(
    .OUTPUT_SIZE_1  (OW),
    .CNT_W          (CW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rst_uut     (rst_uut),
    .end_uut     (end_uut),
    .result_out  (result_out),
    .uut_rst     (uut_rst),
    .uut_end     (uut_end),
    .uut_result  (uut_result),
    .cycle_count (cycle_count),
    .timeout     (timeout)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Outcome of one run: earliest event wins; abort > end > timeout on the same cycle.
  // kind: 0 abort, 1 done, 2 timeout
  function automatic void predict(input int unsigned e, input int unsigned a,
                                  output int kind, output int unsigned stop);
    int unsigned te, ta, tt;
    te = (e != 0) ? e : INF;
    ta = (a != 0) ? a : INF;
    tt = TOUT_EN ? TO : INF;
    stop = te;
    if (ta < stop) stop = ta;
    if (tt < stop) stop = tt;
    if (ta == stop)      kind = 0;
    else if (te == stop) kind = 1;
    else                 kind = 2;
  endfunction

  always @(negedge clk) begin
    if (end_uut && !end_prev) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_end: end_uut=1, expected 0 (no completion pending)");
      end else begin
        mon_e = exp_q.pop_front();
        check("mon_result", result_out, mon_e.result);
        check("mon_cycles", cycle_count, mon_e.cycles);
        check("mon_timeout", timeout, mon_e.tout);
        check("mon_uut_rst", uut_rst, 1);
      end
    end
    end_prev = end_uut;
  end

  task automatic do_run(input int unsigned idle_n, input int unsigned e, input int unsigned a,
                        input logic [OW-1:0] r, input bit rst_in_done);
    int            kind;
    int unsigned   stop;
    logic [OW-1:0] ret_r;
    logic [CW-1:0] ret_c;
    rst_uut = 1'b1;
    repeat (idle_n) begin
      uut_end    = 1'b1;
      uut_result = $urandom;
      @(posedge clk); #1;
      check("idle_end_uut", end_uut, 0);
    end
    predict(e, a, kind, stop);
    ret_r = '0;
    ret_c = '0;
    if (kind == 1) begin
      ret_r = r;
      ret_c = CW'(e);
      exp_q.push_back('{result: r, cycles: CW'(e), tout: 1'b0});
    end else if (kind == 2) begin
      ret_r = '1;
      ret_c = CW'(TO);
      exp_q.push_back('{result: '1, cycles: CW'(TO), tout: 1'b1});
    end
    rst_uut = 1'b0;
    @(posedge clk); #1;
    for (int unsigned n = 1; n <= stop; n++) begin
      if (n == 1) begin
        check("start_result_clear", result_out, 0);
        check("start_count_clear", cycle_count, 0);
      end
      check("run_uut_rst", uut_rst, 0);
      check("run_end_uut", end_uut, 0);
      uut_end    = (n == e);
      uut_result = (n == e) ? r : OW'($urandom);
      rst_uut    = (n == a);
      @(posedge clk); #1;
    end
    if (kind == 0) begin
      check("abort_end_uut", end_uut, 0);
      check("abort_uut_rst", uut_rst, 1);
      check("abort_cycles", cycle_count, 0);
      check("abort_result", result_out, 0);
    end else if (rst_in_done) begin
      rst     = 1'b1;
      rst_uut = 1'b1;
      @(posedge clk); #1;
      check("srst_end_uut", end_uut, 0);
      check("srst_result", result_out, 0);
      check("srst_cycles", cycle_count, 0);
      check("srst_timeout", timeout, 0);
      check("srst_uut_rst", uut_rst, 1);
      rst = 1'b0;
    end else begin
      repeat (3) begin
        uut_end    = 1'($urandom_range(0, 1));
        uut_result = $urandom;
        @(posedge clk); #1;
        check("hold_end_uut", end_uut, 1);
        check("hold_timeout", timeout, (kind == 2));
      end
      rst_uut = 1'b1;
      @(posedge clk); #1;
      check("release_end_uut", end_uut, 0);
      check("release_timeout", timeout, 0);
      check("release_uut_rst", uut_rst, 1);
      check("retain_result", result_out, ret_r);
      check("retain_cycles", cycle_count, ret_c);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned e, a;
    rst        = 1'b1;
    rst_uut    = 1'b1;
    uut_end    = 1'b0;
    uut_result = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_end_uut", end_uut, 0);
    check("reset_result", result_out, 0);
    check("reset_cycles", cycle_count, 0);
    check("reset_timeout", timeout, 0);
    check("reset_uut_rst", uut_rst, 1);
    rst = 1'b0;

    do_run(5, 37, 0, 32'hCAFE_F00D, 1'b0);
`ifdef UUT_RUN_TIMEOUT_EN
    do_run(2, 0, 0, 32'h1111_2222, 1'b0);
    do_run(2, 16, 0, 32'h5A5A_0016, 1'b0);
`endif
    do_run(3, 10, 10, 32'h1234_5678, 1'b0);
    do_run(2, 4, 0, 32'h0000_0404, 1'b0);
    do_run(4, 1, 0, 32'hA5A5_0001, 1'b0);
    do_run(2, 7, 0, 32'hDEAD_BEEF, 1'b1);

`ifndef UUT_RUN_TIMEOUT_EN
    rst_uut = 1'b0;
    uut_end = 1'b0;
    repeat (2000) begin
      @(posedge clk); #1;
      check("long_end_uut", end_uut, 0);
      check("long_timeout", timeout, 0);
    end
    rst_uut = 1'b1;
    @(posedge clk); #1;
    check("long_abort_uut_rst", uut_rst, 1);
`endif

    for (int i = 0; i < 40; i++) begin
      e = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 24);
      a = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 24) : 0;
      if (!TOUT_EN && e == 0 && a == 0) e = $urandom_range(1, 24);
      do_run($urandom_range(0, 3), e, a, $urandom, ($urandom_range(0, 7) == 0));
    end

    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_completions: got %0d outstanding, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
